// File: rtl/aie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aie_pkg
// Description : Shared header-field positions, switch state encoding and
//               round-robin side encoding for the ring tile router.
// Revision    : 1.0  initial release
// ============================================================================
package aie_pkg;

  // Header flit layout: [7:6] destination rank, [5:3] payload length,
  // [2:0] reserved (carried through untouched).
  localparam int DEST_MSB = 7;
  localparam int DEST_LSB = 6;
  localparam int LEN_MSB  = 5;
  localparam int LEN_LSB  = 3;

  // Router packet state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a header from ring or PE
    FWD   = 2'd1,  // ring payload passing to the downstream FIFO
    EJECT = 2'd2,  // ring payload delivered to the local PE
    INJ   = 2'd3   // PE payload pushed into the ring
  } sw_state_t;

  // Which side won the most recent header arbitration.
  typedef enum logic {
    RR_RING = 1'b0,
    RR_PE   = 1'b1
  } rr_t;

  // Destination rank carried in a header flit.
  function automatic logic [1:0] hdr_dest(input logic [7:0] hdr);
    return hdr[DEST_MSB:DEST_LSB];
  endfunction

  // Number of payload flits following a header flit.
  function automatic logic [2:0] hdr_len(input logic [7:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_switch_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter (ring vs PE). When both
//               sides request, the side that did not win last is granted.
//               The pointer only moves when the caller reports that the
//               granted header actually transferred.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import aie_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_ring,
  input  logic req_pe,
  input  logic update,
  output logic grant_ring,
  output logic grant_pe
);

  rr_t rr;

  // Grant the lone requester, or the side opposite the last winner on a tie.
  always_comb begin
    grant_ring = req_ring && (!req_pe || (rr == RR_PE));
    grant_pe   = req_pe   && (!req_ring || (rr == RR_RING));
  end

  // Remember the winner only once its header has really moved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= RR_RING;
    end else if (update) begin
      rr <= grant_pe ? RR_PE : RR_RING;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ring_switch.sv
`default_nettype none
// ============================================================================
// Module      : ring_switch
// Description : Per-tile router between the ring of synchronous FIFOs and the
//               local compute tile. Pops flits from the upstream FIFO and
//               either ejects them to the PE or forwards them downstream, and
//               injects PE packets into the ring. Ring/PE arbitration happens
//               only at packet boundaries; the datapath has no added latency.
// Revision    : 1.0  initial release
// ============================================================================
module ring_switch
  import aie_pkg::*;
#(
  parameter int RANK   = 0,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // upstream ring FIFO (first-word-fall-through)
  input  logic [DATA_W-1:0] ring_rd_data,
  input  logic              ring_rd_empty,
  output logic              ring_rd_en,
  // downstream ring FIFO
  output logic [DATA_W-1:0] ring_wr_data,
  input  logic              ring_wr_full,
  output logic              ring_wr_en,
  // ejection towards the PE
  output logic [DATA_W-1:0] pe_out_data,
  output logic              pe_out_valid,
  input  logic              pe_out_ready,
  // injection from the PE
  input  logic [DATA_W-1:0] pe_in_data,
  input  logic              pe_in_valid,
  output logic              pe_in_ready,
  // ejected packet counter
  output logic [7:0]        eject_count
);

  localparam logic [1:0] MY_RANK = RANK[1:0];

  sw_state_t   state;
  logic [2:0]  rem;

  logic        grant_ring;
  logic        grant_pe;
  logic        rr_update;

  logic [2:0]  ring_len;
  logic [2:0]  pe_len;
  logic        ring_local;

  // Header fields of whatever currently sits at each input.
  always_comb begin
    ring_len   = hdr_len(ring_rd_data[7:0]);
    pe_len     = hdr_len(pe_in_data[7:0]);
    ring_local = (hdr_dest(ring_rd_data[7:0]) == MY_RANK);
  end

  // Header arbitration is only meaningful while idle.
  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_ring   ((state == IDLE) && !ring_rd_empty),
    .req_pe     ((state == IDLE) && pe_in_valid),
    .update     (rr_update),
    .grant_ring (grant_ring),
    .grant_pe   (grant_pe)
  );

  // Handshakes and data steering; every enable implies a completed transfer.
  always_comb begin
    ring_rd_en   = 1'b0;
    ring_wr_en   = 1'b0;
    ring_wr_data = '0;
    pe_out_valid = 1'b0;
    pe_out_data  = '0;
    pe_in_ready  = 1'b0;

    unique case (state)
      IDLE: begin
        if (grant_ring) begin
          if (ring_local) begin
            // own header is consumed here and never shown to the PE
            ring_rd_en = 1'b1;
          end else if (!ring_wr_full) begin
            ring_rd_en   = 1'b1;
            ring_wr_en   = 1'b1;
            ring_wr_data = ring_rd_data;
          end
        end else if (grant_pe && !ring_wr_full) begin
          // PE headers always go onto the ring, even if addressed to us
          pe_in_ready  = 1'b1;
          ring_wr_en   = 1'b1;
          ring_wr_data = pe_in_data;
        end
      end
      FWD: begin
        if (!ring_rd_empty && !ring_wr_full) begin
          ring_rd_en   = 1'b1;
          ring_wr_en   = 1'b1;
          ring_wr_data = ring_rd_data;
        end
      end
      EJECT: begin
        if (!ring_rd_empty) begin
          pe_out_valid = 1'b1;
          pe_out_data  = ring_rd_data;
          ring_rd_en   = pe_out_ready;
        end
      end
      INJ: begin
        if (pe_in_valid && !ring_wr_full) begin
          pe_in_ready  = 1'b1;
          ring_wr_en   = 1'b1;
          ring_wr_data = pe_in_data;
        end
      end
      default: begin
        ring_rd_en = 1'b0;
      end
    endcase

    // Nothing may move while the tile is held in reset.
    if (reset) begin
      ring_rd_en   = 1'b0;
      ring_wr_en   = 1'b0;
      ring_wr_data = '0;
      pe_out_valid = 1'b0;
      pe_out_data  = '0;
      pe_in_ready  = 1'b0;
    end
  end

  // The arbiter pointer moves only when a granted header transfers.
  always_comb begin
    rr_update = (state == IDLE) && (ring_rd_en || pe_in_ready);
  end

  // Packet state machine: tracks payload flits remaining and counts ejections.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= 3'd0;
      eject_count <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ring_rd_en) begin
            rem <= ring_len;
            if (ring_local) begin
              if (ring_len != 3'd0) begin
                state <= EJECT;
              end else begin
                // header-only packet to us is complete on arrival
                eject_count <= eject_count + 8'd1;
              end
            end else if (ring_len != 3'd0) begin
              state <= FWD;
            end
          end else if (pe_in_ready) begin
            rem <= pe_len;
            if (pe_len != 3'd0) begin
              state <= INJ;
            end
          end
        end
        FWD: begin
          if (ring_rd_en) begin
            rem <= rem - 3'd1;
            if (rem == 3'd1) begin
              state <= IDLE;
            end
          end
        end
        EJECT: begin
          if (ring_rd_en) begin
            rem <= rem - 3'd1;
            if (rem == 3'd1) begin
              state       <= IDLE;
              eject_count <= eject_count + 8'd1;
            end
          end
        end
        INJ: begin
          if (pe_in_ready) begin
            rem <= rem - 3'd1;
            if (rem == 3'd1) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_switch
// Description : Self-checking bench for ring_switch (RANK=1). Surrounds the
//               router with an upstream FIFO, a downstream sink, a PE source
//               and a PE sink, and checks traffic at packet level.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ring_switch;

  localparam int RANK = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ring_rd_data = 8'h00;
  logic       ring_rd_empty = 1'b1;
  logic       ring_rd_en;
  logic [7:0] ring_wr_data;
  logic       ring_wr_full = 1'b0;
  logic       ring_wr_en;
  logic [7:0] pe_out_data;
  logic       pe_out_valid;
  logic       pe_out_ready = 1'b0;
  logic [7:0] pe_in_data = 8'h00;
  logic       pe_in_valid = 1'b0;
  logic       pe_in_ready;
  logic [7:0] eject_count;

  always #5 clk = ~clk;

  ring_switch #(.RANK(RANK), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .ring_rd_data (ring_rd_data),
    .ring_rd_empty(ring_rd_empty),
    .ring_rd_en   (ring_rd_en),
    .ring_wr_data (ring_wr_data),
    .ring_wr_full (ring_wr_full),
    .ring_wr_en   (ring_wr_en),
    .pe_out_data  (pe_out_data),
    .pe_out_valid (pe_out_valid),
    .pe_out_ready (pe_out_ready),
    .pe_in_data   (pe_in_data),
    .pe_in_valid  (pe_in_valid),
    .pe_in_ready  (pe_in_ready),
    .eject_count  (eject_count)
  );

  // environment state
  logic [7:0] ring_q[$];   // upstream FIFO contents
  logic [7:0] pe_q[$];     // PE flits waiting to be injected
  logic [7:0] down_q[$];   // flits pushed downstream
  logic [7:0] ej_q[$];     // flits ejected to the PE
  int         push_cyc[$];
  int         cyc;
  int         hs_viol, wr_seen, pov_seen;
  logic       hold_full, rnd;
  int         nvec, nerr;

  // One clock of environment: drive at negedge, sample #1 later, record transfers.
  task automatic step();
    @(negedge clk);
    ring_rd_empty = (ring_q.size() == 0);
    ring_rd_data  = ring_rd_empty ? 8'h00 : ring_q[0];
    ring_wr_full  = hold_full || (rnd && ($urandom_range(0, 3) == 0));
    pe_out_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    pe_in_valid   = (pe_q.size() != 0) && (!rnd || ($urandom_range(0, 3) != 0));
    pe_in_data    = pe_in_valid ? pe_q[0] : 8'h00;
    #1;
    if (ring_rd_en && ring_rd_empty) hs_viol++;
    if (ring_wr_en && ring_wr_full) hs_viol++;
    if (pe_in_ready && !pe_in_valid) hs_viol++;
    if (pe_out_valid && ring_rd_empty) hs_viol++;
    if (ring_wr_en) wr_seen++;
    if (pe_out_valid) pov_seen++;
    if (ring_rd_en && !ring_rd_empty) void'(ring_q.pop_front());
    if (ring_wr_en && !ring_wr_full) begin
      down_q.push_back(ring_wr_data);
      push_cyc.push_back(cyc);
    end
    if (pe_out_valid && pe_out_ready) ej_q.push_back(pe_out_data);
    if (pe_in_valid && pe_in_ready) void'(pe_q.pop_front());
    cyc++;
  endtask

  task automatic clear_env();
    ring_q.delete(); pe_q.delete(); down_q.delete(); ej_q.delete(); push_cyc.delete();
    hs_viol = 0; wr_seen = 0; pov_seen = 0; hold_full = 1'b0; rnd = 1'b0;
    ring_rd_empty = 1'b1; ring_rd_data = 8'h00; pe_in_valid = 1'b0; pe_in_data = 8'h00;
    ring_wr_full = 1'b0; pe_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_env();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset must silence every output even with traffic offered on all sides.
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    ring_rd_empty = 1'b0; ring_rd_data = 8'h88;
    pe_in_valid = 1'b1; pe_in_data = 8'hC0;
    ring_wr_full = 1'b0; pe_out_ready = 1'b1;
    #1;
    nvec++;
    if ({ring_rd_en, ring_wr_en, pe_out_valid, pe_in_ready} !== 4'b0000) begin
      nerr++; $display("FAIL reset_handshakes: got %b expected 0000",
                       {ring_rd_en, ring_wr_en, pe_out_valid, pe_in_ready});
    end
    nvec++;
    if (ring_wr_data !== 8'h00 || pe_out_data !== 8'h00) begin
      nerr++; $display("FAIL reset_data: got wr=%h out=%h expected 00/00", ring_wr_data, pe_out_data);
    end
    nvec++;
    if (eject_count !== 8'h00) begin
      nerr++; $display("FAIL reset_count: got %0d expected 0", eject_count);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_env();
  endtask

  // Local packet: header swallowed, payload to PE, nothing sent downstream.
  task automatic test_eject();
    do_reset();
    ring_q = '{8'h50, 8'hAA, 8'hBB};
    for (int i = 0; i < 20 && ej_q.size() < 2; i++) step();
    step();
    nvec++;
    if (ej_q.size() != 2 || ej_q[0] !== 8'hAA || ej_q[1] !== 8'hBB) begin
      nerr++; $display("FAIL eject_payload: got %0d flits first=%h expected AA,BB",
                       ej_q.size(), (ej_q.size() > 0) ? ej_q[0] : 8'hxx);
    end
    nvec++;
    if (eject_count !== 8'd1) begin
      nerr++; $display("FAIL eject_count: got %0d expected 1", eject_count);
    end
    nvec++;
    if (wr_seen != 0) begin
      nerr++; $display("FAIL eject_no_forward: ring_wr_en seen %0d times expected 0", wr_seen);
    end
  endtask

  // Foreign packet passes downstream in back-to-back cycles with no delay.
  task automatic test_forward();
    int c0;
    do_reset();
    ring_q = '{8'h88, 8'h11};
    c0 = cyc;
    for (int i = 0; i < 4; i++) step();
    nvec++;
    if (down_q.size() != 2 || down_q[0] !== 8'h88 || down_q[1] !== 8'h11) begin
      nerr++; $display("FAIL forward_data: got %0d flits expected 88,11", down_q.size());
    end else begin
      nvec++;
      if (push_cyc[0] != c0 || push_cyc[1] != c0 + 1) begin
        nerr++; $display("FAIL forward_latency: pushed at +%0d,+%0d expected +0,+1",
                         push_cyc[0] - c0, push_cyc[1] - c0);
      end
    end
    nvec++;
    if (ej_q.size() != 0) begin
      nerr++; $display("FAIL forward_no_eject: got %0d ejected expected 0", ej_q.size());
    end
  endtask

  // Contending single-flit packets alternate, PE first after reset.
  task automatic test_arbitration();
    logic [7:0] exp_q[$];
    do_reset();
    ring_q = '{8'h81, 8'h82, 8'h83};
    pe_q   = '{8'hC1, 8'hC2, 8'hC3};
    exp_q  = '{8'hC1, 8'h81, 8'hC2, 8'h82, 8'hC3, 8'h83};
    for (int i = 0; i < 20 && down_q.size() < 6; i++) step();
    nvec++;
    if (down_q.size() != 6) begin
      nerr++; $display("FAIL arb_count: got %0d flits expected 6", down_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nvec++;
        if (down_q[i] !== exp_q[i]) begin
          nerr++; $display("FAIL arb_order[%0d]: got %h expected %h", i, down_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // Downstream back-pressure in the middle of an injected packet.
  task automatic test_inj_stall();
    logic [7:0] exp_q[$];
    do_reset();
    pe_q  = '{8'h58, 8'h01, 8'h02, 8'h03};
    exp_q = '{8'h58, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 20 && down_q.size() < 2; i++) step();
    hold_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++;
      if (pe_in_ready !== 1'b0 || ring_wr_en !== 1'b0) begin
        nerr++; $display("FAIL inj_stall[%0d]: ready=%b wr_en=%b expected 0/0", i, pe_in_ready, ring_wr_en);
      end
    end
    hold_full = 1'b0;
    for (int i = 0; i < 20 && down_q.size() < 4; i++) step();
    nvec++;
    if (down_q.size() != 4) begin
      nerr++; $display("FAIL inj_count: got %0d flits expected 4", down_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (down_q[i] !== exp_q[i]) begin
          nerr++; $display("FAIL inj_order[%0d]: got %h expected %h", i, down_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // Reset during a forward leaves no residue; next packet handled normally.
  task automatic test_reset_mid_fwd();
    do_reset();
    ring_q = '{8'h40, 8'h98};
    for (int i = 0; i < 20 && down_q.size() < 1; i++) step();
    nvec++;
    if (eject_count !== 8'd1) begin
      nerr++; $display("FAIL midrst_pre_count: got %0d expected 1", eject_count);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_env();
    @(negedge clk);
    reset = 1'b0;
    #1;
    nvec++;
    if ({ring_rd_en, ring_wr_en, pe_out_valid, pe_in_ready} !== 4'b0000 || eject_count !== 8'd0) begin
      nerr++; $display("FAIL midrst_outputs: hs=%b count=%0d expected 0000/0",
                       {ring_rd_en, ring_wr_en, pe_out_valid, pe_in_ready}, eject_count);
    end
    ring_q = '{8'h48, 8'h5A};
    for (int i = 0; i < 20 && ej_q.size() < 1; i++) step();
    step();
    nvec++;
    if (ej_q.size() != 1 || ej_q[0] !== 8'h5A || eject_count !== 8'd1 || wr_seen != 0) begin
      nerr++; $display("FAIL midrst_after: ej=%0d count=%0d wr=%0d expected 1 flit 5A/1/0",
                       ej_q.size(), eject_count, wr_seen);
    end
  endtask

  // 256 header-only local packets wrap the counter without any PE traffic.
  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) ring_q.push_back(8'h40);
    for (int i = 0; i < 400 && ring_q.size() > 1; i++) step();
    step();
    nvec++;
    if (eject_count !== 8'd255) begin
      nerr++; $display("FAIL wrap_255: got %0d expected 255", eject_count);
    end
    step();
    nvec++;
    if (eject_count !== 8'd0 || ring_q.size() != 0) begin
      nerr++; $display("FAIL wrap_0: got %0d left=%0d expected 0/0", eject_count, ring_q.size());
    end
    nvec++;
    if (pov_seen != 0 || wr_seen != 0) begin
      nerr++; $display("FAIL wrap_quiet: pe_out_valid %0d wr_en %0d expected 0/0", pov_seen, wr_seen);
    end
  endtask

  // Random traffic with random stalls, checked packet-by-packet.
  task automatic test_random();
    logic [7:0] fwd_flat[$];
    logic [7:0] pe_flat[$];
    logic [7:0] ej_exp[$];
    logic [7:0] hdr, b;
    logic [1:0] d;
    logic [2:0] l;
    int n_ej, total, idx, n;
    bit ok_f, ok_p;
    do_reset();
    n_ej = 0;
    for (int p = 0; p < 40; p++) begin
      d = 2'($urandom_range(0, 3));
      l = 3'($urandom_range(0, 7));
      hdr = {d, l, 3'($urandom_range(0, 7))};
      ring_q.push_back(hdr);
      if (d == 2'(RANK)) n_ej++;
      else fwd_flat.push_back(hdr);
      for (int k = 0; k < int'(l); k++) begin
        b = 8'($urandom);
        ring_q.push_back(b);
        if (d == 2'(RANK)) ej_exp.push_back(b);
        else fwd_flat.push_back(b);
      end
    end
    for (int p = 0; p < 20; p++) begin
      l = 3'($urandom_range(0, 7));
      hdr = {2'($urandom_range(0, 3)), l, 3'($urandom_range(0, 7))};
      pe_q.push_back(hdr); pe_flat.push_back(hdr);
      for (int k = 0; k < int'(l); k++) begin
        b = 8'($urandom);
        pe_q.push_back(b); pe_flat.push_back(b);
      end
    end
    total = fwd_flat.size() + pe_flat.size();
    rnd = 1'b1;
    for (int i = 0; i < 6000 &&
         (down_q.size() < total || ej_q.size() < ej_exp.size() || ring_q.size() != 0); i++) step();
    rnd = 1'b0;
    step();
    nvec++;
    if (down_q.size() != total || ej_q.size() != ej_exp.size() || ring_q.size() != 0 || pe_q.size() != 0) begin
      nerr++; $display("FAIL rand_drain: down %0d/%0d ej %0d/%0d left ring=%0d pe=%0d",
                       down_q.size(), total, ej_q.size(), ej_exp.size(), ring_q.size(), pe_q.size());
    end
    // each downstream packet must be the next whole packet of one source
    idx = 0;
    while (idx < down_q.size()) begin
      n = int'(down_q[idx][5:3]) + 1;
      ok_f = (fwd_flat.size() >= n) && (idx + n <= down_q.size());
      ok_p = (pe_flat.size() >= n) && (idx + n <= down_q.size());
      for (int k = 0; k < n; k++) begin
        if (ok_f && fwd_flat[k] !== down_q[idx + k]) ok_f = 1'b0;
        if (ok_p && pe_flat[k] !== down_q[idx + k]) ok_p = 1'b0;
      end
      nvec++;
      if (ok_f) begin
        for (int k = 0; k < n; k++) void'(fwd_flat.pop_front());
      end else if (ok_p) begin
        for (int k = 0; k < n; k++) void'(pe_flat.pop_front());
      end else begin
        nerr++; $display("FAIL rand_down_pkt@%0d: header %h matches neither ring nor PE stream",
                         idx, down_q[idx]);
        break;
      end
      idx += n;
    end
    nvec++;
    if (fwd_flat.size() != 0 || pe_flat.size() != 0) begin
      nerr++; $display("FAIL rand_down_left: got %0d/%0d unsent expected 0/0", fwd_flat.size(), pe_flat.size());
    end
    for (int i = 0; i < ej_exp.size() && i < ej_q.size(); i++) begin
      nvec++;
      if (ej_q[i] !== ej_exp[i]) begin
        nerr++; $display("FAIL rand_eject[%0d]: got %h expected %h", i, ej_q[i], ej_exp[i]);
      end
    end
    nvec++;
    if (eject_count !== 8'(n_ej)) begin
      nerr++; $display("FAIL rand_count: got %0d expected %0d", eject_count, n_ej);
    end
    nvec++;
    if (hs_viol != 0) begin
      nerr++; $display("FAIL rand_handshake: got %0d enable-without-transfer cycles expected 0", hs_viol);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    clear_env();
    test_reset();
    test_eject();
    test_forward();
    test_arbitration();
    test_inj_stall();
    test_reset_mid_fwd();
    test_count_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
